// File: rtl/ysyx_24080006_id_queue.sv
// Decode stage: one-entry fetch slot, RAW scoreboard on rd, and a DEPTH-entry decoded FIFO to EXU.
// Supports redirect flush and one instruction per cycle when there are no hazards.
module ysyx_24080006_id_queue #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned REG_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_inst,
  output logic [REG_WIDTH-1:0] rs1_addr,
  output logic [REG_WIDTH-1:0] rs2_addr,
  input  logic [31:0]          rs1_data,
  input  logic [31:0]          rs2_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_inst,
  output logic [31:0]          out_rs1_data,
  output logic [31:0]          out_rs2_data,
  input  logic                 wb_valid,
  input  logic [REG_WIDTH-1:0] wb_rd
);

  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned NumRegs = 1 << REG_WIDTH;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // Fetch slot
  logic        slot_v_q;
  logic [31:0] slot_pc_q;
  logic [31:0] slot_inst_q;

  // Decoded-entry FIFO
  logic [31:0]          ent_pc_q   [DEPTH];
  logic [31:0]          ent_inst_q [DEPTH];
  logic [31:0]          ent_rs1_q  [DEPTH];
  logic [31:0]          ent_rs2_q  [DEPTH];
  logic [REG_WIDTH-1:0] ent_rd_q   [DEPTH];
  logic [DEPTH-1:0]     ent_wrd_q;
  logic [DEPTH-1:0]     ent_v_q;
  logic [PtrW-1:0]      head_q, tail_q;
  logic [CntW-1:0]      count_q;

  logic [NumRegs-1:0] busy_q, busy_d;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [REG_WIDTH-1:0] slot_rd;
  logic                 writes_rd, uses_rs1, uses_rs2;
  logic                 fifo_hit_rs1, fifo_hit_rs2;
  logic                 hazard;
  logic                 slot_go, take, pop;

  assign opcode   = slot_inst_q[6:0];
  assign funct3   = slot_inst_q[14:12];
  assign slot_rd  = slot_inst_q[7 +: REG_WIDTH];
  assign rs1_addr = slot_inst_q[15 +: REG_WIDTH];
  assign rs2_addr = slot_inst_q[20 +: REG_WIDTH];

  always_comb begin
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    unique case (opcode)
      OpLui, OpAuipc, OpJal: writes_rd = 1'b1;
      OpJalr, OpLoad, OpImm: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
      end
      OpReg: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OpBranch, OpStore: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpSystem: begin
        writes_rd = (funct3 != 3'd0);
        uses_rs1  = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      default: ;
    endcase
    if (slot_rd == '0) writes_rd = 1'b0;
  end

  // Producers still in the FIFO have not yet marked busy[], so they are matched here.
  always_comb begin
    fifo_hit_rs1 = 1'b0;
    fifo_hit_rs2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_v_q[i] && ent_wrd_q[i]) begin
        if (ent_rd_q[i] == rs1_addr) fifo_hit_rs1 = 1'b1;
        if (ent_rd_q[i] == rs2_addr) fifo_hit_rs2 = 1'b1;
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (uses_rs1 && (rs1_addr != '0) && (busy_q[rs1_addr] || fifo_hit_rs1)) hazard = 1'b1;
    if (uses_rs2 && (rs2_addr != '0) && (busy_q[rs2_addr] || fifo_hit_rs2)) hazard = 1'b1;
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign slot_go   = slot_v_q && !hazard && ((count_q < DepthCnt) || pop) && !flush;
  assign in_ready  = !slot_v_q || slot_go;
  assign take      = in_valid && in_ready && !flush;

  assign out_pc       = out_valid ? ent_pc_q[head_q]   : '0;
  assign out_inst     = out_valid ? ent_inst_q[head_q] : '0;
  assign out_rs1_data = out_valid ? ent_rs1_q[head_q]  : '0;
  assign out_rs2_data = out_valid ? ent_rs2_q[head_q]  : '0;

  // Set wins over a same-cycle writeback clear of the same rd.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (pop && ent_wrd_q[head_q]) busy_d[ent_rd_q[head_q]] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_v_q    <= 1'b0;
      slot_pc_q   <= '0;
      slot_inst_q <= '0;
    end else if (flush) begin
      slot_v_q <= 1'b0;
    end else if (take) begin
      slot_v_q    <= 1'b1;
      slot_pc_q   <= in_pc;
      slot_inst_q <= in_inst;
    end else if (slot_go) begin
      slot_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ent_v_q   <= '0;
      ent_wrd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= '0;
        ent_inst_q[i] <= '0;
        ent_rs1_q[i]  <= '0;
        ent_rs2_q[i]  <= '0;
        ent_rd_q[i]   <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ent_v_q <= '0;
    end else begin
      if (pop) begin
        ent_v_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (slot_go) begin
        ent_pc_q[tail_q]   <= slot_pc_q;
        ent_inst_q[tail_q] <= slot_inst_q;
        ent_rs1_q[tail_q]  <= rs1_data;
        ent_rs2_q[tail_q]  <= rs2_data;
        ent_rd_q[tail_q]   <= slot_rd;
        ent_wrd_q[tail_q]  <= writes_rd;
        ent_v_q[tail_q]    <= 1'b1;
        tail_q             <= tail_q + 1'b1;
      end
      if (slot_go && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !slot_go) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule
